// File: rtl/irq_ctrl.sv
// Edge-triggered, priority-nesting interrupt controller with a 3-deep active stack.
// Sources are edge-latched into PEND. The lowest-index unmasked pending source preempts only a lower-priority handler.
module irq_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] VEC_BASE  = 16'h0020,
    parameter int          VEC_SHIFT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_int_en,
    input  logic             i_iret_detected,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_addr,
    input  logic [15:0]      i_cfg_wdata,
    output logic [15:0]      o_cfg_rdata,
    output logic             o_irq_take,
    output logic [15:0]      o_irq_vector,
    output logic [1:0]       o_irq_depth,
    output logic [2:0]       o_active_src
);

    // state | meaning
    // IDLE  | waiting for an eligible candidate
    // TAKE  | o_irq_take high, vector valid, stack already pushed
    // HOLD  | one-cycle gap before the next take may be considered
    typedef enum logic [1:0] {IDLE, TAKE, HOLD} state_t;

    state_t             state_q, state_d;
    logic               rst_meta, rst_sync_n;
    logic [N_SRC-1:0]   irq_prev, pend, mask, rise, cand_vec, w1c, take_clr;
    logic               ctrl_en, cand_valid, can_take, enter_take;
    logic [2:0]         cand;
    logic [2:0]         stack [3];
    logic [1:0]         depth;
    logic [15:0]        vec_d;

    // Reset asserts immediately and releases two clocks later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) {rst_sync_n, rst_meta} <= 2'b00;
        else          {rst_sync_n, rst_meta} <= {rst_meta, 1'b1};
    end

    assign rise       = i_irq & ~irq_prev;
    assign cand_vec   = pend & mask;
    assign cand_valid = |cand_vec;

    always_comb begin
        cand = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (cand_vec[i]) cand = 3'(i);
    end

    always_comb begin
        case (depth)
            2'd1:    o_active_src = stack[0];
            2'd2:    o_active_src = stack[1];
            2'd3:    o_active_src = stack[2];
            default: o_active_src = 3'd0;
        endcase
    end

    assign can_take = cand_valid && ctrl_en && i_int_en && !i_iret_detected &&
                      (depth != 2'd3) && ((depth == 2'd0) || (cand < o_active_src));
    assign enter_take = (state_q == IDLE) && can_take;
    assign vec_d      = VEC_BASE + (16'(cand) << VEC_SHIFT);
    assign w1c        = (i_cfg_we && i_cfg_addr == 2'd2) ? i_cfg_wdata[N_SRC-1:0] : '0;
    assign take_clr   = enter_take ? (N_SRC'(1) << cand) : '0;

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_take) state_d = TAKE;
            TAKE:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_irq_take  = (state_q == TAKE);
    assign o_irq_depth = depth;

    // A new edge outranks any clear landing on the same bit.
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            irq_prev     <= '0;
            pend         <= '0;
            mask         <= '0;
            ctrl_en      <= 1'b0;
            o_irq_vector <= VEC_BASE;
        end else begin
            irq_prev <= i_irq;
            pend     <= (pend & ~w1c & ~take_clr) | rise;
            if (i_cfg_we && i_cfg_addr == 2'd0) ctrl_en <= i_cfg_wdata[0];
            if (i_cfg_we && i_cfg_addr == 2'd1) mask    <= i_cfg_wdata[N_SRC-1:0];
            if (enter_take) o_irq_vector <= vec_d;
        end
    end

    // Push and pop never coincide: a take is blocked while IRET is asserted.
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            depth <= 2'd0;
            for (int i = 0; i < 3; i++) stack[i] <= 3'd0;
        end else if (enter_take) begin
            depth <= depth + 2'd1;
            for (int i = 0; i < 3; i++)
                if (depth == 2'(i)) stack[i] <= cand;
        end else if (i_iret_detected && depth != 2'd0) begin
            depth <= depth - 2'd1;
            for (int i = 0; i < 3; i++)
                if (depth == 2'(i + 1)) stack[i] <= 3'd0;
        end
    end

    always_comb begin
        o_cfg_rdata = 16'h0000;
        case (i_cfg_addr)
            2'd0: o_cfg_rdata[0]         = ctrl_en;
            2'd1: o_cfg_rdata[N_SRC-1:0] = mask;
            2'd2: o_cfg_rdata[N_SRC-1:0] = pend;
            2'd3: o_cfg_rdata[4:0]       = {depth, o_active_src};
            default: o_cfg_rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; expected vectors are queued at stimulus time and popped on each take.
module tb_irq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  i_irq;
    logic        i_int_en;
    logic        i_iret_detected;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_addr;
    logic [15:0] i_cfg_wdata;
    logic [15:0] o_cfg_rdata;
    logic        o_irq_take;
    logic [15:0] o_irq_vector;
    logic [1:0]  o_irq_depth;
    logic [2:0]  o_active_src;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic        prev_take = 1'b0;

    irq_ctrl dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_irq           (i_irq),
        .i_int_en        (i_int_en),
        .i_iret_detected (i_iret_detected),
        .i_cfg_we        (i_cfg_we),
        .i_cfg_addr      (i_cfg_addr),
        .i_cfg_wdata     (i_cfg_wdata),
        .o_cfg_rdata     (o_cfg_rdata),
        .o_irq_take      (o_irq_take),
        .o_irq_vector    (o_irq_vector),
        .o_irq_depth     (o_irq_depth),
        .o_active_src    (o_active_src)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [15:0] exp);
        i_cfg_addr = addr;
        #1;
        check(tag, o_cfg_rdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        i_cfg_we = 1'b1; i_cfg_addr = addr; i_cfg_wdata = data;
        tick(1);
        i_cfg_we = 1'b0;
    endtask

    task automatic pulse(input int k);
        i_irq[k] = 1'b1;
        tick(1);
        i_irq[k] = 1'b0;
    endtask

    task automatic iret(input int n);
        i_iret_detected = 1'b1;
        tick(n);
        i_iret_detected = 1'b0;
    endtask

    // Scoreboard side: every take must match the oldest queued vector and last one cycle.
    always @(negedge i_clk) begin
        if (o_irq_take) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL unexpected_take observed=%h expected=none", o_irq_vector);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                assert (o_irq_vector === e) else begin
                    bad++;
                    $error("FAIL take_vector observed=%h expected=%h", o_irq_vector, e);
                end
            end
            if (prev_take) begin
                bad++;
                $error("FAIL take_width observed=2+ cycles expected=1");
            end
        end
        prev_take = o_irq_take;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_irq = '0; i_int_en = 1'b0; i_iret_detected = 1'b0;
        i_cfg_we = 1'b0; i_cfg_addr = 2'd0; i_cfg_wdata = '0;
        tick(3);
        check("rst_take",   16'(o_irq_take),   16'h0);
        check("rst_depth",  16'(o_irq_depth),  16'h0);
        check("rst_vector", o_irq_vector,      16'h0020);
        check("rst_active", 16'(o_active_src), 16'h0);
        check_reg("rst_ctrl", 2'd0, 16'h0000);
        i_rst_n = 1'b1;
        tick(3);

        iret(4);
        check("stray_iret_depth", 16'(o_irq_depth), 16'h0);

        cfg_write(2'd0, 16'h0001);
        cfg_write(2'd1, 16'h00FF);
        i_int_en = 1'b1;
        check_reg("ctrl_rd", 2'd0, 16'h0001);
        check_reg("mask_rd", 2'd1, 16'h00FF);

        // single take from source 3
        exp_q.push_back(16'h002C);
        pulse(3);
        check("single_latency", 16'(o_irq_take), 16'h0);
        check_reg("single_pend_set", 2'd2, 16'h0008);
        tick(1);
        check("single_take",   16'(o_irq_take),   16'h1);
        check("single_vector", o_irq_vector,      16'h002C);
        check("single_depth",  16'(o_irq_depth),  16'h1);
        check("single_active", 16'(o_active_src), 16'h3);
        check_reg("single_pend_clr", 2'd2, 16'h0000);
        check_reg("single_status",   2'd3, 16'h000B);
        tick(1);
        check("single_take_drop", 16'(o_irq_take), 16'h0);
        check("single_vec_hold",  o_irq_vector,    16'h002C);
        iret(1);
        check("single_iret_depth", 16'(o_irq_depth), 16'h0);

        // nesting: 3 then 1 preempts, 5 waits
        exp_q.push_back(16'h002C);
        pulse(3);
        tick(1);
        check("nest_d1", 16'(o_irq_depth), 16'h1);
        tick(2);
        exp_q.push_back(16'h0024);
        pulse(1);
        tick(1);
        check("nest_take1",   16'(o_irq_take),   16'h1);
        check("nest_vec1",    o_irq_vector,      16'h0024);
        check("nest_d2",      16'(o_irq_depth),  16'h2);
        check("nest_active1", 16'(o_active_src), 16'h1);
        tick(2);
        pulse(5);
        tick(2);
        check_reg("nest_pend5", 2'd2, 16'h0020);
        check("nest_d2_hold", 16'(o_irq_depth), 16'h2);
        iret(1);
        check("nest_pop1", 16'(o_irq_depth), 16'h1);
        tick(1);
        check("nest_no_take5", 16'(o_irq_take), 16'h0);
        exp_q.push_back(16'h0034);
        iret(1);
        check("nest_pop0", 16'(o_irq_depth), 16'h0);
        tick(1);
        check("nest_take5",   16'(o_irq_take),   16'h1);
        check("nest_vec5",    o_irq_vector,      16'h0034);
        check("nest_active5", 16'(o_active_src), 16'h5);
        tick(1);
        iret(1);
        check("nest_done", 16'(o_irq_depth), 16'h0);

        // saturation at depth 3
        exp_q.push_back(16'h0028);
        pulse(2); tick(3);
        exp_q.push_back(16'h0024);
        pulse(1); tick(3);
        exp_q.push_back(16'h0020);
        pulse(0); tick(1);
        check("sat_d3",     16'(o_irq_depth),  16'h3);
        check("sat_active", 16'(o_active_src), 16'h0);
        tick(2);
        pulse(1);
        tick(3);
        check_reg("sat_pend1", 2'd2, 16'h0002);
        check("sat_d3_hold", 16'(o_irq_depth), 16'h3);
        iret(1);
        tick(3);
        check("sat_d2",        16'(o_irq_depth),  16'h2);
        check("sat_active1",   16'(o_active_src), 16'h1);
        check_reg("sat_pend_kept", 2'd2, 16'h0002);
        cfg_write(2'd2, 16'h0002);
        iret(2);
        check("sat_unwind", 16'(o_irq_depth), 16'h0);

        // masking, gating, W1C and set-beats-clear
        cfg_write(2'd1, 16'h0000);
        pulse(0);
        i_irq[6] = 1'b1;
        i_cfg_we = 1'b1; i_cfg_addr = 2'd2; i_cfg_wdata = 16'h0040;
        tick(1);
        i_cfg_we = 1'b0; i_irq[6] = 1'b0;
        tick(2);
        check_reg("mask_pend", 2'd2, 16'h0041);
        check("mask_no_take", 16'(o_irq_depth), 16'h0);
        i_int_en = 1'b0;
        cfg_write(2'd1, 16'h0001);
        tick(3);
        check("inten_no_take", 16'(o_irq_depth), 16'h0);
        cfg_write(2'd2, 16'h0041);
        check_reg("w1c_clear", 2'd2, 16'h0000);
        cfg_write(2'd3, 16'hFFFF);
        check_reg("status_ro", 2'd3, 16'h0000);
        i_int_en = 1'b1;

        // async reset in the middle of a take
        cfg_write(2'd1, 16'h00FF);
        pulse(3);
        tick(1);
        check("rst_mid_take_pre", 16'(o_irq_take), 16'h1);
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_take",   16'(o_irq_take),  16'h0);
        check("rst_mid_depth",  16'(o_irq_depth), 16'h0);
        check("rst_mid_vector", o_irq_vector,     16'h0020);
        tick(2);
        i_rst_n = 1'b1;
        tick(3);
        check_reg("post_rst_ctrl", 2'd0, 16'h0000);
        check("queue_drained", 16'(exp_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
